romtest_scanner: RTL and testbench
==================================

Name: romtest_scanner

Overview:
- Address-sequencing front end for the romtest application.
- On a start pulse it walks a synchronous ROM from address 0 to 2^ADDR_WIDTH-1 and absorbs the ROM's one-cycle read latency.
- Returned words go out as a valid/ready stream of (address, data, last) beats through a 2-entry skid FIFO, so downstream backpressure never loses or duplicates a word.
- It also accumulates a 16-bit additive checksum for the harness-side checker.

Parameters:
- ADDR_WIDTH, 8, ROM address width; the scan covers 0 .. 2^ADDR_WIDTH-1.
- DATA_WIDTH, 8, ROM data width.

Ports:
- clk  input  1  single clock; all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a scan when in IDLE or DONE.
- rom_en  output  1  read issue strobe, combinational.
- rom_addr  output  ADDR_WIDTH  read address, registered.
- rom_dout  input  DATA_WIDTH  ROM data, valid exactly one cycle after the cycle rom_en was high.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head.
- out_addr  output  ADDR_WIDTH  address of the head beat.
- out_data  output  DATA_WIDTH  data of the head beat.
- out_last  output  1  head beat is address 2^ADDR_WIDTH-1.
- busy  output  1  state is SCAN or DRAIN.
- done  output  1  state is DONE.
- checksum  output  16  sum mod 2^16 of out_data over accepted beats.

Behaviour:
- Reset (async, any time, including mid-scan):
  - state=IDLE, rom_addr=0, inflight=0, FIFO count=0.
  - checksum=0; out_valid=0, busy=0, done=0.
  - Any read in flight is discarded.
- States:
  - IDLE -start-> SCAN.
  - SCAN -(issue of final address)-> DRAIN.
  - DRAIN -(pop of the beat with out_last)-> DONE.
  - DONE -start-> SCAN.
- Start handling:
  - Entering SCAN clears checksum and sets rom_addr=0.
  - start is ignored in SCAN and DRAIN.
- Issue and credit:
  - pop = out_valid & out_ready.
  - rom_en = (state==SCAN) & (count - pop + inflight < 2).
  - On issue, rom_addr increments. It wraps to 0 after the final address, and the wrap is harmless because state leaves SCAN.
  - inflight <= rom_en. A tag register holds the issued address and last flag.
- Capture: when inflight=1, {tag, rom_dout} is written to the FIFO tail at that edge.
  - Simultaneous push and pop keeps count unchanged.
  - count never exceeds 2; reaching 3 is a design error and must be asserted in simulation.
- Output:
  - out_* is driven from the FIFO head and is stable while out_valid & !out_ready.
  - Beats appear in strictly increasing address order.
- Checksum: on each pop, checksum <= checksum + zero-extended out_data. Updated at the same edge as the pop.
- Latency:
  - start sampled at edge E0.
  - rom_en=1 for addr 0 in cycle after E0.
  - Data is captured at the following edge.
  - out_valid for addr 0 is first seen two cycles after E0.
- Throughput: with out_ready held high, one beat per cycle, no bubbles after the first.
- Backpressure: with out_ready low, at most 2 beats are buffered and rom_en stays low until credit returns.
- End of scan: done asserts the cycle after the last beat pops and stays high until start or rst. The final checksum is valid while done=1.

Test Plan:
- ROM model data = addr ^ 8'h5A, out_ready=1, start pulse → 256 beats on consecutive cycles, addresses 0..255, out_last only on addr 255; done=1 with checksum=16'h7F80; busy low afterwards.
- Random out_ready (50%) over a full scan → every addr 0..255 seen exactly once and in order; out_* stable while stalled; checksum=16'h7F80; FIFO count never exceeds 2.
- Hold out_ready low for 10 cycles starting at beat 20 → exactly 2 entries buffered (addr 20, 21); rom_en low throughout the stall; on release, beats 20, 21, 22… continue without gaps.
- start pulses during SCAN and DRAIN → ignored; checksum not cleared; exactly 256 beats delivered.
- rst asserted asynchronously at beat 100 → out_valid, busy, done and checksum drop immediately. A new start gives a clean scan from addr 0 with checksum=16'h7F80.
- In DONE, a second start → checksum clears to 0, done deasserts the next cycle, and a second full identical scan completes.

Source files
------------

// File: rtl/romtest_scanner.sv
// rtl/romtest_scanner.sv - ROM address sequencer that absorbs the one-cycle read latency,
// streams (addr, data, last) beats through a 2-entry skid FIFO and sums accepted data.
module romtest_scanner #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_dout,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic [15:0]           checksum
);
   localparam int ENTRY_WIDTH = 1 + ADDR_WIDTH + DATA_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    inflight;
   logic [ADDR_WIDTH-1:0]   tag_addr;
   logic                    tag_last;
   logic [ENTRY_WIDTH-1:0]  fifo_mem [2];
   logic                    rd_ptr;
   logic                    wr_ptr;
   logic [1:0]              count;
   logic [2:0]              count_next;
   logic [2:0]              credit_use;
   logic                    pop;
   logic                    push;
   logic                    start_scan;
   logic                    final_issue;

   assign pop        = out_valid & out_ready;
   assign push       = inflight;
   assign out_valid  = (count != 2'd0);
   assign {out_last, out_addr, out_data} = fifo_mem[rd_ptr];

   // Entries still owed a FIFO slot after this edge: buffered beats minus the one
   // leaving now, plus the read whose data lands at this edge.
   assign credit_use = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};
   assign count_next = {1'b0, count} + {2'b00, push} - {2'b00, pop};

   always_comb begin
      state_next  = state;
      rom_en      = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      start_scan  = 1'b0;
      final_issue = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               start_scan = 1'b1;
               state_next = SCAN;
            end
         end
         SCAN: begin
            busy   = 1'b1;
            rom_en = (credit_use < 3'd2);
            if (rom_en && (rom_addr == LAST_ADDR)) begin
               final_issue = 1'b1;
               state_next  = DRAIN;
            end
         end
         DRAIN: begin
            busy = 1'b1;
            if (pop && out_last)
               state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               start_scan = 1'b1;
               state_next = SCAN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         rom_addr <= '0;
         inflight <= 1'b0;
         tag_addr <= '0;
         tag_last <= 1'b0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= 2'd0;
         checksum <= 16'd0;
      end else begin
         state    <= state_next;
         inflight <= rom_en;
         if (start_scan) begin
            rom_addr <= '0;
         end else if (rom_en) begin
            rom_addr <= rom_addr + 1'b1;
            tag_addr <= rom_addr;
            tag_last <= final_issue;
         end
         if (push)
            wr_ptr <= ~wr_ptr;
         if (pop)
            rd_ptr <= ~rd_ptr;
         count <= count_next[1:0];
         if (start_scan)
            checksum <= 16'd0;
         else if (pop)
            checksum <= checksum + 16'(out_data);
      end
   end

   // Payload storage needs no reset: out_valid gates every read of it.
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {tag_last, tag_addr, rom_dout};
   end

   always_ff @(posedge clk) begin
      if (!rst)
         assert (count_next <= 3'd2);
   end

endmodule

// File: tb/tb_romtest_scanner.sv
// tb/tb_romtest_scanner.sv - directed scans with random backpressure against a
// beat-sequence reference model of the romtest_scanner stream.
module tb_romtest_scanner;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int N  = 256;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          rom_en;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_dout;
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic          done;
   logic [15:0]   checksum;

   int checks = 0;
   int errors = 0;

   logic [DW-1:0] rom_img [N];
   int            exp_idx;
   int            issued;
   int            popped;
   int            cyc;
   int            stall_cnt;
   logic [15:0]   model_sum;
   bit            last_popped;
   bit            prev_stall;
   logic [17:0]   prev_beat;

   romtest_scanner #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start),
      .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last),
      .busy(busy), .done(done), .checksum(checksum)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rom_en)
         rom_dout <= rom_img[rom_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      exp_idx = 0; issued = 0; popped = 0; cyc = 0; stall_cnt = 0;
      model_sum = 16'd0; last_popped = 1'b0; prev_stall = 1'b0;
   endtask

   task automatic cycle(input bit rdy, input bit st, input int mode, input bit stalled);
      bit pop;
      bit iss;
      @(negedge clk);
      out_ready = rdy;
      start = st;
      #1;
      iss = rom_en;
      pop = out_valid & out_ready;
      if (cyc == 0) begin
         chk("lat_rom_en", rom_en, 1);
         chk("lat_rom_addr", rom_addr, 0);
         chk("lat_valid_c0", out_valid, 0);
      end
      if (cyc == 1) chk("lat_valid_c1", out_valid, 0);
      if (cyc == 2) chk("lat_valid_c2", out_valid, 1);
      if (out_valid) begin
         chk("beat_in_range", exp_idx < N, 1);
         chk("beat_addr", out_addr, exp_idx % N);
         chk("beat_data", out_data, rom_img[exp_idx % N]);
         chk("beat_last", out_last, exp_idx == N - 1);
      end
      if (prev_stall)
         chk("stall_stable", {out_valid, out_last, out_addr, out_data}, {1'b1, prev_beat[16:0]});
      if (iss) begin
         chk("issue_in_range", issued < N, 1);
         chk("issue_addr", rom_addr, issued % N);
      end
      chk("credit", (issued + iss - popped - pop) <= 2, 1);
      chk("checksum", checksum, model_sum);
      chk("done", done, last_popped);
      chk("busy", busy, !last_popped);
      if (mode != 1 && popped >= 1 && popped < N)
         chk("no_bubble", out_valid, 1);
      if (stalled) begin
         chk("stall_rom_en", rom_en, 0);
         chk("stall_buffered", issued - popped, 2);
         chk("stall_head", out_addr, 20);
      end
      if (last_popped) begin
         chk("end_valid", out_valid, 0);
         chk("end_checksum", checksum, 16'h7F80);
      end
      prev_stall = out_valid & !out_ready;
      prev_beat  = {out_valid, out_last, out_addr, out_data};
      if (pop) begin
         model_sum = model_sum + {8'd0, rom_img[exp_idx % N]};
         exp_idx++;
         popped++;
         if (exp_idx == N) last_popped = 1'b1;
      end
      if (iss) issued++;
      cyc++;
   endtask

   // mode 0: ready high; 1: random ready; 2: 10-cycle stall at beat 20; 3: start pulses mid-scan
   task automatic run_scan(input int mode);
      int guard;
      bit rdy;
      bit st;
      bit stalled;
      guard = 0;
      while (!last_popped && guard < 3000) begin
         rdy = 1'b1; st = 1'b0; stalled = 1'b0;
         if (mode == 1) rdy = ($urandom_range(0, 1) == 1);
         if (mode == 2 && exp_idx == 20 && stall_cnt < 10) begin
            rdy = 1'b0; stalled = 1'b1; stall_cnt++;
         end
         if (mode == 3 && (exp_idx == 50 || (exp_idx == N - 1 && out_valid))) st = 1'b1;
         cycle(rdy, st, mode, stalled);
         guard++;
      end
      chk("scan_timeout", guard < 3000, 1);
      chk("beat_count", popped, N);
      for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, mode, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < N; i++) rom_img[i] = DW'(i) ^ 8'h5A;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      last_popped = 1'b0; prev_stall = 1'b0;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_checksum", checksum, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_rom_en", rom_en, 0);
      @(negedge clk);
      rst = 1'b0;

      do_start(); run_scan(0);
      do_start(); run_scan(0);
      do_start(); run_scan(1);
      do_start(); run_scan(2);
      do_start(); run_scan(3);

      do_start();
      while (exp_idx < 100 && cyc < 1000) cycle(1'b1, 1'b0, 0, 1'b0);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_valid", out_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_checksum", checksum, 0);
      chk("arst_rom_en", rom_en, 0);
      @(negedge clk);
      rst = 1'b0;
      do_start(); run_scan(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
